health_bank: RTL and testbench
==============================

// Module: health_bank
// PURPOSE
//   Parametrised per-player health store for N tanks, with hit processing.
//   Adds saturating damage, per-player invulnerability cooldown, elimination
//   tracking and a sticky game-over/winner flag, beside a CPU read/write port.
//   Sits between the CPU memory map and the collision/projectile logic; the
//   flat health bus feeds the HUD/VGA renderer.
// PARAMETERS
//   NUM_PLAYERS   2    number of health entries (2..16)
//   DATA_WIDTH    32   width of each health value
//   ADDR_WIDTH    1    CPU address width; 2**ADDR_WIDTH >= NUM_PLAYERS
//   MAX_HEALTH    100  reset/initial health; CPU writes are clamped to it
//   HIT_COOLDOWN  50   invulnerability cycles after an accepted hit (>=1)
//   PID_WIDTH     1    width of hit_player; 2**PID_WIDTH >= NUM_PLAYERS
// PORTS
//   clk          in   1                       system clock
//   reset        in   1                       synchronous, active-high reset
//   wEn          in   1                       CPU write enable
//   readEn       in   1                       CPU read enable
//   addr         in   ADDR_WIDTH              CPU player index
//   dataIn       in   DATA_WIDTH              CPU write data
//   dataOut      out  DATA_WIDTH              registered CPU read data
//   hit_valid    in   1                       hit request strobe, one cycle
//   hit_player   in   PID_WIDTH               player being hit
//   hit_damage   in   DATA_WIDTH              damage amount, unsigned
//   hit_applied  out  1                       pulse: hit accepted this cycle
//   invuln       out  NUM_PLAYERS             bit i high while cooldown[i] != 0
//   alive        out  NUM_PLAYERS             bit i high while health[i] != 0
//   game_over    out  1                       sticky: <=1 player alive
//   winner       out  PID_WIDTH               sole survivor index, valid w/ game_over
//   draw         out  1                       game_over with zero survivors
//   allContents  out  DATA_WIDTH*NUM_PLAYERS  health[i] at [(i+1)*DW-1 : i*DW]
// BEHAVIOUR
//   - Reset (sync, overrides all, including a hit/write in the same cycle):
//     health[i]=MAX_HEALTH, cooldown[i]=0, dataOut=0, hit_applied=0,
//     game_over=0, winner=0, draw=0.
//   - CPU read: readEn -> dataOut = health[addr] next edge (1-cycle latency).
//     dataOut holds otherwise. addr >= NUM_PLAYERS reads 0. A read in the same
//     cycle as a write/hit to that entry returns the pre-update value.
//   - CPU write: wEn -> health[addr] = min(dataIn, MAX_HEALTH) next edge.
//     addr >= NUM_PLAYERS is ignored. Writes work after game_over and may revive
//     a player. They do not clear game_over.
//   - Hit accepted iff hit_valid & hit_player < NUM_PLAYERS & cooldown[p]==0 &
//     health[p]!=0 & !game_over & !(wEn & addr==p). The CPU write wins a
//     same-player collision.
//   - On accept: health[p] = (damage >= health[p]) ? 0 : health[p]-damage.
//     cooldown[p] = HIT_COOLDOWN. hit_applied = 1 for one cycle after the edge.
//     Rejected hits change nothing.
//   - Cooldown: each counter decrements by 1 per cycle while nonzero, and
//     saturates at 0. Player p is invulnerable for exactly HIT_COOLDOWN cycles
//     after the accept edge.
//   - alive, invuln, allContents: combinational from the state registers.
//   - game_over state machine: PLAYING -> OVER on the edge after the alive count
//     becomes <=1. The check runs one cycle after the health update.
//     In OVER: winner = index of the single alive player; if none, draw=1 and
//     winner=0. winner and draw are frozen at entry. OVER exits only on reset.
// TESTING
//   1 reset; readEn addr=1 -> dataOut=100 next cycle; allContents={100,100}.
//   2 hit p0 dmg=30 -> health0=70, hit_applied pulse, invuln[0]=1 for 50 cycles;
//     second hit at cycle +10 rejected (70 kept), at +50 accepted (40).
//   3 hit p1 dmg=250 from 100 -> health1=0 (no wrap), alive=2'b01,
//     then game_over=1, winner=0, draw=0; later hits on p0 ignored.
//   4 wEn addr=0 dataIn=500 with hit on p0 same cycle -> health0=100, hit_applied=0.
//   5 reset during cooldown/OVER -> all health 100, invuln=0, game_over=0 next cycle.

Source files
------------

// File: rtl/health_bank_if.sv
// Bus bundle for health_bank: CPU read/write port plus the hit-request port
// from the collision/projectile logic.
//   master: drives wEn, readEn, addr, dataIn, hit_valid, hit_player, hit_damage;
//           receives dataOut and hit_applied.
//   slave : the health bank side (mirror of master).
interface health_bank_if #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 32,
    parameter int PID_WIDTH  = 1
);
    logic                  wEn;
    logic                  readEn;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] dataIn;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  hit_valid;
    logic [PID_WIDTH-1:0]  hit_player;
    logic [DATA_WIDTH-1:0] hit_damage;
    logic                  hit_applied;

    modport master (
        output wEn, readEn, addr, dataIn, hit_valid, hit_player, hit_damage,
        input  dataOut, hit_applied
    );

    modport slave (
        input  wEn, readEn, addr, dataIn, hit_valid, hit_player, hit_damage,
        output dataOut, hit_applied
    );
endinterface

// File: rtl/health_bank.sv
// Per-player health store for NUM_PLAYERS tanks with hit processing.
// Saturating damage, per-player invulnerability cooldown, elimination tracking
// and a sticky game-over/winner/draw result, next to a CPU read/write port.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : CPU port (wEn, readEn, addr, dataIn, dataOut registered)
//                  and hit port (hit_valid, hit_player, hit_damage, hit_applied)
//   invuln       : bit i set while player i's cooldown is running
//   alive        : bit i set while health[i] != 0
//   game_over    : sticky, at most one player left alive
//   winner       : sole survivor index, meaningful with game_over
//   draw         : game_over with nobody left alive
//   allContents  : health[i] at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
module health_bank #(
    parameter int NUM_PLAYERS  = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 1,
    parameter int MAX_HEALTH   = 100,
    parameter int HIT_COOLDOWN = 50,
    parameter int PID_WIDTH    = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    health_bank_if.slave                      bus,
    output logic [NUM_PLAYERS-1:0]            invuln,
    output logic [NUM_PLAYERS-1:0]            alive,
    output logic                              game_over,
    output logic [PID_WIDTH-1:0]              winner,
    output logic                              draw,
    output logic [DATA_WIDTH*NUM_PLAYERS-1:0] allContents
);

    localparam int                  CD_W    = $clog2(HIT_COOLDOWN + 1);
    localparam logic [DATA_WIDTH-1:0] MAX_H = DATA_WIDTH'(MAX_HEALTH);
    localparam logic [CD_W-1:0]     CD_LOAD = CD_W'(HIT_COOLDOWN);

    typedef enum logic {PLAYING = 1'b0, OVER = 1'b1} state_t;

    logic [DATA_WIDTH-1:0] health_q [NUM_PLAYERS];
    logic [DATA_WIDTH-1:0] health_d [NUM_PLAYERS];
    logic [CD_W-1:0]       cd_q     [NUM_PLAYERS];
    logic [CD_W-1:0]       cd_d     [NUM_PLAYERS];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  hit_applied_q, hit_applied_d;

    state_t                state_q, state_d;
    logic [PID_WIDTH-1:0]  winner_q, winner_d;
    logic                  draw_q, draw_d;

    logic [NUM_PLAYERS-1:0] hit_sel;
    logic [DATA_WIDTH-1:0]  wr_val;
    int                     alive_cnt;
    logic [PID_WIDTH-1:0]   sole_idx;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_flat
        assign allContents[g*DATA_WIDTH +: DATA_WIDTH] = health_q[g];
        assign alive[g]  = (health_q[g] != '0);
        assign invuln[g] = (cd_q[g] != '0);
    end

    assign bus.dataOut     = data_out_q;
    assign bus.hit_applied = hit_applied_q;

    // Hit acceptance; a CPU write to the same player takes priority.
    always_comb begin
        hit_sel = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (bus.hit_valid && int'(bus.hit_player) == i && cd_q[i] == '0 &&
                health_q[i] != '0 && state_q != OVER &&
                !(bus.wEn && int'(bus.addr) == i)) begin
                hit_sel[i] = 1'b1;
            end
        end
    end

    assign wr_val        = (bus.dataIn > MAX_H) ? MAX_H : bus.dataIn;
    assign hit_applied_d = |hit_sel;

    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            health_d[i] = health_q[i];
            cd_d[i]     = (cd_q[i] != '0) ? cd_q[i] - CD_W'(1) : '0;
            if (bus.wEn && int'(bus.addr) == i) begin
                health_d[i] = wr_val;
            end else if (hit_sel[i]) begin
                // Damage saturates at zero instead of wrapping.
                health_d[i] = (bus.hit_damage >= health_q[i]) ? '0
                                                               : health_q[i] - bus.hit_damage;
                cd_d[i]     = CD_LOAD;
            end
        end
    end

    // Read returns the pre-update value; out-of-range index reads zero.
    always_comb begin
        data_out_d = data_out_q;
        if (bus.readEn) begin
            data_out_d = '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (int'(bus.addr) == i) data_out_d = health_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                health_q[i] <= MAX_H;
                cd_q[i]     <= '0;
            end
            data_out_q    <= '0;
            hit_applied_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                health_q[i] <= health_d[i];
                cd_q[i]     <= cd_d[i];
            end
            data_out_q    <= data_out_d;
            hit_applied_q <= hit_applied_d;
        end
    end

    // Survivor count from registered health, so the game-over decision lands
    // one cycle after the health update that caused it.
    always_comb begin
        alive_cnt = 0;
        sole_idx  = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (health_q[i] != '0) begin
                alive_cnt = alive_cnt + 1;
                sole_idx  = PID_WIDTH'(i);
            end
        end
    end

    // Game-state FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PLAYING;
            winner_q <= '0;
            draw_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            draw_q   <= draw_d;
        end
    end

    // Game-state FSM: next state. Result is captured once on entry to OVER.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        draw_d   = draw_q;
        if (state_q == PLAYING && alive_cnt <= 1) begin
            state_d  = OVER;
            winner_d = (alive_cnt == 1) ? sole_idx : '0;
            draw_d   = (alive_cnt == 0);
        end
    end

    // Game-state FSM: outputs.
    always_comb begin
        game_over = (state_q == OVER);
        winner    = winner_q;
        draw      = draw_q;
    end

endmodule

// File: tb/tb_health_bank.sv
// Bench for health_bank: directed scenarios checked against fixed expected
// values, then a randomized run checked against a cycle-level reference model
// that tracks health as integers, invulnerability as "cycles since last
// accepted hit", and the game result as a sticky flag.
module tb_health_bank;
    localparam int NP   = 2;
    localparam int DW   = 32;
    localparam int AW   = 1;
    localparam int PW   = 1;
    localparam int MAXH = 100;
    localparam int COOL = 50;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    health_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PID_WIDTH(PW)) bus ();

    logic [NP-1:0]    invuln, alive;
    logic             game_over, draw;
    logic [PW-1:0]    winner;
    logic [DW*NP-1:0] allContents;

    health_bank #(
        .NUM_PLAYERS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .MAX_HEALTH(MAXH), .HIT_COOLDOWN(COOL), .PID_WIDTH(PW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .invuln(invuln), .alive(alive), .game_over(game_over),
        .winner(winner), .draw(draw), .allContents(allContents)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    longint mh [NP];
    longint last_hit [NP];
    longint cyc = 0;
    bit     m_over, m_draw, m_ha;
    int     m_win;
    longint m_dout;

    task automatic model_step(bit r, bit we, bit re, int a, longint din,
                              bit hv, int hp, longint hd);
        int cnt;
        int sole;
        bit acc;
        if (r) begin
            for (int i = 0; i < NP; i++) begin
                mh[i] = MAXH;
                last_hit[i] = -1000;
            end
            m_over = 0; m_draw = 0; m_win = 0; m_dout = 0; m_ha = 0;
        end else begin
            acc = 0;
            if (hv && hp < NP)
                acc = (cyc - last_hit[hp] >= COOL) && mh[hp] != 0 && !m_over &&
                      !(we && a == hp);
            if (re) m_dout = (a < NP) ? mh[a] : 0;
            cnt = 0; sole = 0;
            for (int i = 0; i < NP; i++) if (mh[i] != 0) begin cnt++; sole = i; end
            if (!m_over && cnt <= 1) begin
                m_over = 1;
                m_draw = (cnt == 0);
                m_win  = (cnt == 1) ? sole : 0;
            end
            if (we && a < NP) mh[a] = (din > MAXH) ? MAXH : din;
            if (acc) begin
                mh[hp] = (hd >= mh[hp]) ? 0 : mh[hp] - hd;
                last_hit[hp] = cyc + 1;
            end
            m_ha = acc;
        end
        cyc++;
    endtask

    task automatic tick(bit r, bit we, bit re, int a, logic [31:0] din,
                        bit hv, int hp, logic [31:0] hd);
        reset          = r;
        bus.wEn        = we;
        bus.readEn     = re;
        bus.addr       = a[AW-1:0];
        bus.dataIn     = din;
        bus.hit_valid  = hv;
        bus.hit_player = hp[PW-1:0];
        bus.hit_damage = hd;
        model_step(r, we, re, a, longint'(din), hv, hp, longint'(hd));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic longint health_of(int i);
        return longint'(allContents[i*DW +: DW]);
    endfunction

    task automatic test_reset();
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.dataOut !== 32'd0) begin
            n_fail++; $display("FAIL reset_dataout: got %0d expected 0", bus.dataOut);
        end
        n_checks++;
        if (alive !== 2'b11 || invuln !== 2'b00 || game_over !== 1'b0 || draw !== 1'b0 ||
            winner !== 1'b0 || bus.hit_applied !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got alive=%b invuln=%b go=%b draw=%b win=%0d ha=%b expected 11 00 0 0 0 0",
                     alive, invuln, game_over, draw, winner, bus.hit_applied);
        end
        tick(0, 0, 1, 1, 0, 0, 0, 0);
        n_checks++;
        if (bus.dataOut !== 32'd100) begin
            n_fail++; $display("FAIL reset_read: got %0d expected 100", bus.dataOut);
        end
        n_checks++;
        if (allContents !== {32'd100, 32'd100}) begin
            n_fail++; $display("FAIL reset_contents: got %h expected 64'h%h", allContents, {32'd100, 32'd100});
        end
    endtask

    task automatic test_hit_cooldown();
        int inv_bad;
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1, 0, 30);
        n_checks++;
        if (health_of(0) != 70 || bus.hit_applied !== 1'b1 || invuln !== 2'b01) begin
            n_fail++;
            $display("FAIL hit_first: got h0=%0d ha=%b invuln=%b expected 70 1 01",
                     health_of(0), bus.hit_applied, invuln);
        end
        inv_bad = 0;
        for (int j = 1; j < COOL; j++) begin
            if (j == 10) tick(0, 0, 0, 0, 0, 1, 0, 30);
            else idle();
            if (invuln[0] !== 1'b1) inv_bad++;
            if (j == 10) begin
                n_checks++;
                if (health_of(0) != 70 || bus.hit_applied !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hit_during_cooldown: got h0=%0d ha=%b expected 70 0",
                             health_of(0), bus.hit_applied);
                end
            end
            if (j == 1) begin
                n_checks++;
                if (bus.hit_applied !== 1'b0) begin
                    n_fail++; $display("FAIL hit_pulse_width: got %b expected 0", bus.hit_applied);
                end
            end
        end
        n_checks++;
        if (inv_bad != 0) begin
            n_fail++; $display("FAIL invuln_window: got %0d low cycles expected 0", inv_bad);
        end
        idle();
        n_checks++;
        if (invuln[0] !== 1'b0) begin
            n_fail++; $display("FAIL invuln_end: got %b expected 0", invuln[0]);
        end
        tick(0, 0, 0, 0, 0, 1, 0, 30);
        n_checks++;
        if (health_of(0) != 40 || bus.hit_applied !== 1'b1 || invuln[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_after_cooldown: got h0=%0d ha=%b inv=%b expected 40 1 1",
                     health_of(0), bus.hit_applied, invuln[0]);
        end
    endtask

    task automatic test_overkill();
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1, 1, 250);
        n_checks++;
        if (health_of(1) != 0 || alive !== 2'b01 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL overkill_health: got h1=%0d alive=%b go=%b expected 0 01 0",
                     health_of(1), alive, game_over);
        end
        idle();
        n_checks++;
        if (game_over !== 1'b1 || winner !== 1'b0 || draw !== 1'b0) begin
            n_fail++;
            $display("FAIL overkill_result: got go=%b win=%0d draw=%b expected 1 0 0",
                     game_over, winner, draw);
        end
        tick(0, 0, 0, 0, 0, 1, 0, 10);
        n_checks++;
        if (health_of(0) != 100 || bus.hit_applied !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_after_over: got h0=%0d ha=%b expected 100 0",
                     health_of(0), bus.hit_applied);
        end
    endtask

    task automatic test_draw_and_revive();
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        // Write player 0 to zero while player 1 is killed by a hit.
        tick(0, 1, 0, 0, 0, 1, 1, 200);
        idle();
        n_checks++;
        if (game_over !== 1'b1 || draw !== 1'b1 || winner !== 1'b0 || alive !== 2'b00) begin
            n_fail++;
            $display("FAIL draw_result: got go=%b draw=%b win=%0d alive=%b expected 1 1 0 00",
                     game_over, draw, winner, alive);
        end
        tick(0, 1, 0, 1, 50, 0, 0, 0);
        idle();
        n_checks++;
        if (health_of(1) != 50 || game_over !== 1'b1 || draw !== 1'b1 || winner !== 1'b0) begin
            n_fail++;
            $display("FAIL revive_after_over: got h1=%0d go=%b draw=%b win=%0d expected 50 1 1 0",
                     health_of(1), game_over, draw, winner);
        end
    endtask

    task automatic test_write_collision();
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 500, 1, 0, 30);
        n_checks++;
        if (health_of(0) != 100 || bus.hit_applied !== 1'b0 || invuln[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL write_wins: got h0=%0d ha=%b inv=%b expected 100 0 0",
                     health_of(0), bus.hit_applied, invuln[0]);
        end
        tick(0, 1, 1, 0, 20, 0, 0, 0);
        n_checks++;
        if (bus.dataOut !== 32'd100 || health_of(0) != 20) begin
            n_fail++;
            $display("FAIL read_during_write: got dout=%0d h0=%0d expected 100 20",
                     bus.dataOut, health_of(0));
        end
        tick(0, 1, 0, 1, 99, 0, 0, 0);
        tick(0, 0, 1, 1, 0, 0, 0, 0);
        n_checks++;
        if (bus.dataOut !== 32'd99) begin
            n_fail++; $display("FAIL write_read_back: got %0d expected 99", bus.dataOut);
        end
        idle();
        n_checks++;
        if (bus.dataOut !== 32'd99) begin
            n_fail++; $display("FAIL dataout_hold: got %0d expected 99", bus.dataOut);
        end
    endtask

    task automatic test_reset_midgame();
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1, 0, 20);
        tick(0, 0, 1, 0, 0, 1, 1, 150);
        idle();
        // Reset wins over a simultaneous hit and write.
        tick(1, 1, 0, 1, 7, 1, 0, 50);
        n_checks++;
        if (allContents !== {32'd100, 32'd100} || invuln !== 2'b00 || game_over !== 1'b0 ||
            draw !== 1'b0 || winner !== 1'b0 || bus.hit_applied !== 1'b0 || bus.dataOut !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_midgame: got all=%h inv=%b go=%b draw=%b win=%0d ha=%b dout=%0d expected all 100, rest 0",
                     allContents, invuln, game_over, draw, winner, bus.hit_applied, bus.dataOut);
        end
    endtask

    task automatic test_random();
        logic [DW*NP-1:0] exp_all;
        logic [NP-1:0]    exp_inv, exp_alive;
        bit r, we, re, hv;
        int a, hp;
        logic [31:0] din, hd;
        int e_all, e_dout, e_ha, e_inv, e_alive, e_res;
        e_all = 0; e_dout = 0; e_ha = 0; e_inv = 0; e_alive = 0; e_res = 0;
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 2000; c++) begin
            r   = ($urandom_range(0, 79) == 0);
            we  = ($urandom_range(0, 11) == 0);
            re  = ($urandom_range(0, 2) == 0);
            a   = $urandom_range(0, NP - 1);
            din = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 130));
            hv  = ($urandom_range(0, 1) == 0);
            hp  = $urandom_range(0, NP - 1);
            hd  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 45));
            tick(r, we, re, a, din, hv, hp, hd);
            for (int i = 0; i < NP; i++) begin
                exp_all[i*DW +: DW] = mh[i][DW-1:0];
                exp_inv[i]   = (cyc - last_hit[i] < COOL);
                exp_alive[i] = (mh[i] != 0);
            end
            n_checks++;
            if (allContents !== exp_all) begin
                n_fail++; e_all++;
                if (e_all < 5) $display("FAIL rnd_contents c=%0d: got %h expected %h", c, allContents, exp_all);
            end
            n_checks++;
            if (bus.dataOut !== m_dout[DW-1:0]) begin
                n_fail++; e_dout++;
                if (e_dout < 5) $display("FAIL rnd_dataout c=%0d: got %0d expected %0d", c, bus.dataOut, m_dout);
            end
            n_checks++;
            if (bus.hit_applied !== m_ha) begin
                n_fail++; e_ha++;
                if (e_ha < 5) $display("FAIL rnd_hit_applied c=%0d: got %b expected %b", c, bus.hit_applied, m_ha);
            end
            n_checks++;
            if (invuln !== exp_inv) begin
                n_fail++; e_inv++;
                if (e_inv < 5) $display("FAIL rnd_invuln c=%0d: got %b expected %b", c, invuln, exp_inv);
            end
            n_checks++;
            if (alive !== exp_alive) begin
                n_fail++; e_alive++;
                if (e_alive < 5) $display("FAIL rnd_alive c=%0d: got %b expected %b", c, alive, exp_alive);
            end
            n_checks++;
            if (game_over !== m_over || draw !== m_draw || int'(winner) != m_win) begin
                n_fail++; e_res++;
                if (e_res < 5)
                    $display("FAIL rnd_result c=%0d: got go=%b draw=%b win=%0d expected %b %b %0d",
                             c, game_over, draw, winner, m_over, m_draw, m_win);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.wEn        = 1'b0;
        bus.readEn     = 1'b0;
        bus.addr       = '0;
        bus.dataIn     = '0;
        bus.hit_valid  = 1'b0;
        bus.hit_player = '0;
        bus.hit_damage = '0;
        test_reset();
        test_hit_cooldown();
        test_overkill();
        test_draw_and_revive();
        test_write_collision();
        test_reset_midgame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
